// File: rtl/intersection_sequencer.sv
// -----------------------------------------------------------------------------
// intersection_sequencer
//   Traffic-light sequencer for a main road crossed by a side street.
//   Phases cycle MG -> MY -> SG -> SY -> MG. Main green is held for a minimum
//   of 2*tbase cycles and then until side-street demand is seen. Side green
//   runs tbase cycles and may be extended once by text cycles if a vehicle is
//   still present at the end of the base period.
//
// Parameters
//   tbase : side-green base time in cycles; main-green minimum is 2*tbase (1..15)
//   tyel  : yellow time in cycles, either road (1..31)
//   text  : single side-green extension in cycles, 0 disables (0..31)
//
// Ports
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous active-low reset
//   side_st    in   1  side-street vehicle sensor (level, synchronous)
//   main_light out  2  main lamp: 1 red, 2 yellow, 3 green
//   side_light out  2  side lamp, same encoding
//   phase      out  2  0 MG, 1 MY, 2 SG, 3 SY
// -----------------------------------------------------------------------------
module intersection_sequencer #(
  parameter int tbase = 6,
  parameter int tyel  = 2,
  parameter int text  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       side_st,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic [1:0] phase
);

  typedef enum logic [1:0] {
    MG = 2'd0,
    MY = 2'd1,
    SG = 2'd2,
    SY = 2'd3
  } phase_t;

  localparam logic [1:0] LAMP_RED = 2'd1;
  localparam logic [1:0] LAMP_YEL = 2'd2;
  localparam logic [1:0] LAMP_GRN = 2'd3;

  // Terminal counts: each phase ends on the edge where count equals these.
  localparam logic [4:0] MG_LAST  = 5'(2 * tbase - 1);
  localparam logic [4:0] YEL_LAST = 5'(tyel - 1);
  localparam logic [4:0] SG_LAST  = 5'(tbase - 1);
  localparam logic [4:0] EXT_LAST = (text > 0) ? 5'(text - 1) : 5'd0;
  localparam bit         EXT_EN   = (text > 0);

  phase_t     state_q, state_d;
  logic [4:0] count_q, count_d;
  logic       req_q, req_d;
  logic       ext_q, ext_d;
  logic [1:0] main_d, side_d;

  // NOTE: every signal gets a default before the case so no path can leave
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q + 5'd1;
    req_d   = req_q;
    ext_d   = ext_q;

    case (state_q)
      MG: begin
        if (side_st) req_d = 1'b1;
        if (count_q == MG_LAST) begin
          count_d = count_q;  // saturate: minimum served, wait for demand
          if (req_q || side_st) begin
            state_d = MY;
            count_d = 5'd0;
          end
        end
      end

      MY: begin
        if (side_st) req_d = 1'b1;
        if (count_q == YEL_LAST) begin
          state_d = SG;
          count_d = 5'd0;
          req_d   = 1'b0;  // demand is being served; clear wins over a new set
        end
      end

      SG: begin
        if (ext_q) begin
          if (count_q == EXT_LAST) begin
            state_d = SY;
            count_d = 5'd0;
            ext_d   = 1'b0;
          end
        end else if (count_q == SG_LAST) begin
          if (side_st && EXT_EN) begin
            ext_d   = 1'b1;  // one extension only: ext_q blocks a second one
            count_d = 5'd0;
          end else begin
            state_d = SY;
            count_d = 5'd0;
          end
        end
      end

      SY: begin
        if (count_q == YEL_LAST) begin
          state_d = MG;
          count_d = 5'd0;
        end
      end

      default: begin
        state_d = MG;
        count_d = 5'd0;
      end
    endcase

    // Lamps are decoded from the next phase and registered, so they change on
    // the same edge as phase and never glitch through a shared non-red state.
    main_d = LAMP_RED;
    side_d = LAMP_RED;
    case (state_d)
      MG:      main_d = LAMP_GRN;
      MY:      main_d = LAMP_YEL;
      SG:      side_d = LAMP_GRN;
      SY:      side_d = LAMP_YEL;
      default: main_d = LAMP_GRN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values seen before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MG;
      count_q    <= 5'd0;
      req_q      <= 1'b0;
      ext_q      <= 1'b0;
      main_light <= LAMP_GRN;
      side_light <= LAMP_RED;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      req_q      <= req_d;
      ext_q      <= ext_d;
      main_light <= main_d;
      side_light <= side_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_sequencer.sv
// -----------------------------------------------------------------------------
// tb_intersection_sequencer
//   Directed bench for intersection_sequencer. Per-cycle vectors {side_st,
//   expected phase} are queued per scenario, applied one per rising edge and
//   compared 1 time unit after the edge; lamp expectations follow from the
//   phase. A second instance with text=0 checks the no-extension case, and a
//   negedge monitor checks that both lamps are never non-red together.
// -----------------------------------------------------------------------------
module tb_intersection_sequencer;

  localparam logic [1:0] P_MG = 2'd0;
  localparam logic [1:0] P_MY = 2'd1;
  localparam logic [1:0] P_SG = 2'd2;
  localparam logic [1:0] P_SY = 2'd3;

  typedef struct {
    logic       side;
    logic [1:0] ph;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       side_st = 1'b0;
  logic [1:0] main_light, side_light, phase;
  logic [1:0] main_light2, side_light2, phase2;

  int n_pass  = 0;
  int n_total = 0;
  vec_t vq[$];

  intersection_sequencer #(.tbase(6), .tyel(2), .text(3)) dut (
    .clk(clk), .reset(reset), .side_st(side_st),
    .main_light(main_light), .side_light(side_light), .phase(phase)
  );

  intersection_sequencer #(.tbase(6), .tyel(2), .text(0)) dut_noext (
    .clk(clk), .reset(reset), .side_st(side_st),
    .main_light(main_light2), .side_light(side_light2), .phase(phase2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int exp_main(input logic [1:0] ph);
    case (ph)
      P_MG:    return 3;
      P_MY:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int exp_side(input logic [1:0] ph);
    case (ph)
      P_SG:    return 3;
      P_SY:    return 2;
      default: return 1;
    endcase
  endfunction

  // Safety: never both lamps non-red, on either instance, in or out of reset.
  always @(negedge clk) begin
    assert (!(main_light != 2'd1 && side_light != 2'd1))
      else $error("both lamps non-red: main=%0d side=%0d", main_light, side_light);
    assert (!(main_light2 != 2'd1 && side_light2 != 2'd1))
      else $error("both lamps non-red (text=0): main=%0d side=%0d", main_light2, side_light2);
    check("safety", int'(main_light != 2'd1 && side_light != 2'd1), 0);
    check("safety_noext", int'(main_light2 != 2'd1 && side_light2 != 2'd1), 0);
  end

  task automatic push(input int n, input logic s, input logic [1:0] ph);
    vec_t v;
    v.side = s;
    v.ph   = ph;
    repeat (n) vq.push_back(v);
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vq.size(); i++) begin
      side_st = vq[i].side;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d] phase", name, i), int'(phase), int'(vq[i].ph));
      check($sformatf("%s[%0d] main", name, i), int'(main_light), exp_main(vq[i].ph));
      check($sformatf("%s[%0d] side", name, i), int'(side_light), exp_side(vq[i].ph));
    end
    vq.delete();
  endtask

  // Assert reset, check the reset state, release on a falling edge so the next
  // rising edge is the first cycle of MG.
  task automatic do_reset(input string name);
    side_st = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({name, " rst phase"}, int'(phase), 0);
    check({name, " rst main"}, int'(main_light), 3);
    check({name, " rst side"}, int'(side_light), 1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int len;
    bit found;

    // Idle: no demand for 100 cycles, MG throughout.
    do_reset("idle");
    push(100, 1'b0, P_MG);
    run_vecs("idle");

    // Single-cycle pulse on cycle 3: MG 12, MY 2, SG 6, SY 2, then MG held.
    do_reset("pulse");
    push(2, 1'b0, P_MG);
    push(1, 1'b1, P_MG);
    push(8, 1'b0, P_MG);
    push(2, 1'b0, P_MY);
    push(6, 1'b0, P_SG);
    push(2, 1'b0, P_SY);
    push(15, 1'b0, P_MG);
    run_vecs("pulse");

    // Continuous demand: SG 9 (one extension), SY 2, MG exactly 12, repeat.
    do_reset("held");
    push(11, 1'b1, P_MG);
    push(2, 1'b1, P_MY);
    push(9, 1'b1, P_SG);
    push(2, 1'b1, P_SY);
    push(12, 1'b1, P_MG);
    push(2, 1'b1, P_MY);
    push(9, 1'b1, P_SG);
    push(2, 1'b1, P_SY);
    run_vecs("held");

    // Late demand at MG count 20 (counter saturated): MY on the next edge.
    do_reset("late");
    push(20, 1'b0, P_MG);
    push(1, 1'b1, P_MY);
    push(1, 1'b0, P_MY);
    push(6, 1'b0, P_SG);
    push(2, 1'b0, P_SY);
    push(3, 1'b0, P_MG);
    run_vecs("late");

    // Reset mid-SG (count 4), asserted between edges.
    do_reset("midrst");
    push(1, 1'b1, P_MG);
    push(10, 1'b0, P_MG);
    push(2, 1'b0, P_MY);
    push(5, 1'b0, P_SG);
    run_vecs("midrst");
    reset = 1'b0;
    #1;
    check("midrst async phase", int'(phase), 0);
    check("midrst async main", int'(main_light), 3);
    check("midrst async side", int'(side_light), 1);
    @(negedge clk);
    reset = 1'b1;
    push(11, 1'b1, P_MG);
    push(1, 1'b1, P_MY);
    run_vecs("midrst_after");

    // text=0 instance with demand held: SG exactly 6 cycles, then SY.
    do_reset("noext");
    side_st = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (phase2 == P_SG) found = 1'b1;
    end
    check("noext reached SG", int'(found), 1);
    len = 0;
    while (found && phase2 == P_SG && len < 40) begin
      len++;
      @(posedge clk);
      #1;
    end
    check("noext SG length", len, 6);
    check("noext next phase", int'(phase2), int'(P_SY));
    side_st = 1'b0;

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
